alu_muldiv_seq: RTL and testbench

- Parametrised sequential multiply/divide unit; companion to the combinational ALU in the MIPS datapath.
- Executes MULT/MULTU/DIV/DIVU iteratively, one result bit per cycle, into architectural HI/LO registers.
- Supports MTHI/MTLO writes and continuous HI/LO readout (MFHI/MFLO).
- busy/done handshake lets the pipeline stall on HI/LO hazards.

---
 rtl/alu_muldiv_seq_if.sv | 17 +
 rtl/alu_muldiv_seq.sv | 137 +++++++++++++
 tb/tb_alu_muldiv_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_if.sv
// Request/result bundle for the sequential multiply/divide unit.
// The pipeline side is the master; the HI/LO unit is the slave.
interface alu_muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output start, op, A, B, input busy, done, HI, LO);
    modport slave  (input start, op, A, B, output busy, done, HI, LO);
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Produces one result bit per cycle on unsigned magnitudes, then fixes signs in one extra cycle.
module alu_muldiv_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic              clk,
    input logic              reset,
    alu_muldiv_seq_if.slave  bus
);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opb_q;
    logic                 is_div_q;
    logic                 neg_lo_q;
    logic                 neg_hi_q;
    logic                 div_zero_q;

    logic                 is_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_tmp;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    always_comb begin
        is_signed = (bus.op == OpMult) || (bus.op == OpDiv);
        a_neg     = is_signed && bus.A[WIDTH-1];
        b_neg     = is_signed && bus.B[WIDTH-1];
        a_mag     = a_neg ? -bus.A : bus.A;
        b_mag     = b_neg ? -bus.B : bus.B;
    end

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
        div_tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_tmp - {1'b0, opb_q};
        div_ge   = ~div_diff[WIDTH];
        if (is_div_q) begin
            acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Overflow DIV needs no special case: |min|/1 = min unsigned, remainder 0, quotient sign +.
    always_comb begin
        prod_fix = neg_lo_q ? -acc_q : acc_q;
        quo_fix  = div_zero_q ? '1 :
                   (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            div_zero_q <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.HI     <= '0;
            bus.LO     <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        case (bus.op)
                            OpMult, OpMultu, OpDiv, OpDivu: begin
                                state_q    <= StCalc;
                                bus.busy   <= 1'b1;
                                cnt_q      <= '0;
                                is_div_q   <= bus.op[1];
                                neg_lo_q   <= a_neg ^ b_neg;
                                neg_hi_q   <= a_neg;
                                div_zero_q <= bus.op[1] && (bus.B == '0);
                                opb_q      <= bus.op[1] ? b_mag : a_mag;
                                acc_q      <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                            end
                            OpMthi:  bus.HI <= bus.A;
                            OpMtlo:  bus.LO <= bus.A;
                            default: ;
                        endcase
                    end
                end
                StCalc: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    if (is_div_q) begin
                        bus.HI <= rem_fix;
                        bus.LO <= quo_fix;
                    end else begin
                        bus.HI <= prod_fix[2*WIDTH-1:WIDTH];
                        bus.LO <= prod_fix[WIDTH-1:0];
                    end
                    state_q  <= StIdle;
                    cnt_q    <= '0;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomised and directed bench for alu_muldiv_seq at WIDTH=32 and WIDTH=8,
// checked against an arithmetic reference model.
module tb_alu_muldiv_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_muldiv_seq_if #(.WIDTH(32)) bus32 ();
    alu_muldiv_seq_if #(.WIDTH(8))  bus8 ();

    alu_muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
    alu_muldiv_seq #(.WIDTH(8),  .CNT_W(4)) dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp32_hi = '0, exp32_lo = '0, exp8_hi = '0, exp8_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    task automatic model(input int w, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] hi, output logic [63:0] lo);
        logic [63:0] mask, ua, ub, p;
        longint sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua = a & mask;
        ub = b & mask;
        sa = $signed(ua << (64 - w)) >>> (64 - w);
        sb = $signed(ub << (64 - w)) >>> (64 - w);
        hi = '0;
        lo = '0;
        case (op)
            3'd0, 3'd1: begin
                p  = (op == 3'd0) ? 64'(sa * sb) : ua * ub;
                hi = (p >> w) & mask;
                lo = p & mask;
            end
            default: begin
                if (ub == 0) begin
                    lo = mask;
                    hi = ua;
                end else if (op == 3'd2 && sa == -(longint'(1) << (w - 1)) && sb == -1) begin
                    lo = ua;
                    hi = '0;
                end else if (op == 3'd2) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = 64'(q) & mask;
                    hi = 64'(r) & mask;
                end else begin
                    lo = ua / ub;
                    hi = ua % ub;
                end
            end
        endcase
    endtask

    task automatic drive(input bit w8, input logic st, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        if (w8) begin
            bus8.start = st; bus8.op = op; bus8.A = a[7:0]; bus8.B = b[7:0];
        end else begin
            bus32.start = st; bus32.op = op; bus32.A = a[31:0]; bus32.B = b[31:0];
        end
    endtask

    function automatic logic [63:0] get_busy(input bit w8);
        return w8 ? 64'(bus8.busy) : 64'(bus32.busy);
    endfunction
    function automatic logic [63:0] get_done(input bit w8);
        return w8 ? 64'(bus8.done) : 64'(bus32.done);
    endfunction
    function automatic logic [63:0] get_hi(input bit w8);
        return w8 ? 64'(bus8.HI) : 64'(bus32.HI);
    endfunction
    function automatic logic [63:0] get_lo(input bit w8);
        return w8 ? 64'(bus8.LO) : 64'(bus32.LO);
    endfunction

    // Issues one op from the cycle after an edge; returns with done visible (back-to-back ready).
    task automatic do_op(input bit w8, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input int mthi_at,
                         output logic [63:0] ghi, output logic [63:0] glo);
        int w = w8 ? 8 : 32;
        logic [63:0] mask = w8 ? 64'hFF : 64'hFFFF_FFFF;
        logic [63:0] old_hi, old_lo, ehi, elo;
        int edges, busy_cnt;
        string pfx = $sformatf("w%0d op%0d", w, op);
        old_hi = w8 ? exp8_hi : exp32_hi;
        old_lo = w8 ? exp8_lo : exp32_lo;
        ehi = old_hi;
        elo = old_lo;
        if (op <= 3'd3) model(w, op, a, b, ehi, elo);
        else if (op == 3'd4) ehi = a & mask;
        else if (op == 3'd5) elo = a & mask;
        drive(w8, 1'b1, op, a, b);
        @(posedge clk); #1;
        drive(w8, 1'b0, op, {$urandom, $urandom}, {$urandom, $urandom});
        check({pfx, " done_low_after_start"}, get_done(w8), 64'd0);
        if (op <= 3'd3) begin
            check({pfx, " busy_at_start"}, get_busy(w8), 64'd1);
            busy_cnt = 1;
            edges = 0;
            while (edges < w + 5) begin
                if (mthi_at != 0 && edges == mthi_at) drive(w8, 1'b1, 3'b100, 64'h1234, 64'd0);
                else drive(w8, 1'b0, op, {$urandom, $urandom}, {$urandom, $urandom});
                @(posedge clk); #1;
                edges++;
                if (get_done(w8) == 64'd1) break;
                if (get_busy(w8) == 64'd1) busy_cnt++;
                if (edges == w / 2) begin
                    check({pfx, " hold_hi"}, get_hi(w8), old_hi);
                    check({pfx, " hold_lo"}, get_lo(w8), old_lo);
                end
            end
            drive(w8, 1'b0, op, 64'd0, 64'd0);
            check({pfx, " latency"}, 64'(edges), 64'(w + 1));
            check({pfx, " busy_cycles"}, 64'(busy_cnt), 64'(w + 1));
        end else begin
            check({pfx, " busy_stays_low"}, get_busy(w8), 64'd0);
        end
        ghi = get_hi(w8);
        glo = get_lo(w8);
        check({pfx, " hi"}, ghi, ehi);
        check({pfx, " lo"}, glo, elo);
        if (w8) begin exp8_hi = ehi; exp8_lo = elo; end
        else begin exp32_hi = ehi; exp32_lo = elo; end
    endtask

    task automatic run_dir(input string tag, input bit w8, input logic [2:0] op,
                           input logic [63:0] a, input logic [63:0] b, input int mthi_at,
                           input logic [63:0] ehi, input logic [63:0] elo);
        logic [63:0] ghi, glo;
        do_op(w8, op, a, b, mthi_at, ghi, glo);
        check({tag, " hi_const"}, ghi, ehi);
        check({tag, " lo_const"}, glo, elo);
    endtask

    function automatic logic [63:0] rand_opnd(input bit w8);
        logic [63:0] mask = w8 ? 64'hFF : 64'hFFFF_FFFF;
        logic [63:0] minv = w8 ? 64'h80 : 64'h8000_0000;
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return mask;
            3:       return minv;
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ghi, glo;
        reset = 1'b1;
        drive(1'b0, 1'b0, 3'b110, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 3'b110, 64'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", get_busy(1'b0), 64'd0);
        check("reset done", get_done(1'b0), 64'd0);
        check("reset hi", get_hi(1'b0), 64'd0);
        check("reset lo", get_lo(1'b0), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_dir("mult_neg3x7",   1'b0, 3'd0, 64'hFFFF_FFFD, 64'd7,         0,
                64'hFFFF_FFFF, 64'hFFFF_FFEB);
        run_dir("multu_max",     1'b0, 3'd1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0,
                64'hFFFF_FFFE, 64'd1);
        run_dir("mult_m1xm1",    1'b0, 3'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 64'd0, 64'd1);
        run_dir("div_m7by2",     1'b0, 3'd2, 64'hFFFF_FFF9, 64'd2,         0,
                64'hFFFF_FFFF, 64'hFFFF_FFFD);
        run_dir("divu_7by2",     1'b0, 3'd3, 64'd7,         64'd2,         0, 64'd1, 64'd3);
        run_dir("div_by_zero",   1'b0, 3'd2, 64'd5,         64'd0,         0,
                64'd5, 64'hFFFF_FFFF);
        run_dir("div_overflow",  1'b0, 3'd2, 64'h8000_0000, 64'hFFFF_FFFF, 0,
                64'd0, 64'h8000_0000);
        run_dir("divu_mthi_ign", 1'b0, 3'd3, 64'd100,       64'd7,         5, 64'd2, 64'd14);
        run_dir("w8_mult_min",   1'b1, 3'd0, 64'h80,        64'h80,        0, 64'h40, 64'h00);
        run_dir("w8_divu",       1'b1, 3'd3, 64'hFF,        64'h10,        0, 64'h0F, 64'h0F);

        // Asynchronous reset in the middle of a DIVU.
        drive(1'b0, 1'b1, 3'd3, 64'd1000, 64'd7);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd3, 64'd0, 64'd0);
        repeat (9) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        check("async_reset busy", get_busy(1'b0), 64'd0);
        check("async_reset hi", get_hi(1'b0), 64'd0);
        check("async_reset lo", get_lo(1'b0), 64'd0);
        #2 reset = 1'b0;
        exp32_hi = '0; exp32_lo = '0; exp8_hi = '0; exp8_lo = '0;
        @(posedge clk); #1;
        check("post_reset idle", get_busy(1'b0), 64'd0);
        run_dir("mtlo_after_reset", 1'b0, 3'd5, 64'hABCD, 64'd0, 0, 64'd0, 64'hABCD);

        for (int i = 0; i < 40; i++) begin
            do_op(1'b0, 3'($urandom_range(0, 7)), rand_opnd(1'b0), rand_opnd(1'b0), 0, ghi, glo);
        end
        for (int i = 0; i < 25; i++) begin
            do_op(1'b1, 3'($urandom_range(0, 7)), rand_opnd(1'b1), rand_opnd(1'b1), 0, ghi, glo);
        end
        @(posedge clk); #1;
        check("final done low", get_done(1'b0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
